// File: rtl/prescaler_multi_channel.sv
// Multi-channel runtime-programmable clock prescaler. Each channel divides clk_in by its own
// ratio. A new ratio is staged in a shadow register and only applied at a period boundary.
module prescaler_multi_channel #(
  parameter int                NUM_CH      = 4,
  parameter int                DIV_WIDTH   = 16,
  parameter int                DEFAULT_DIV = 32,
  parameter logic [NUM_CH-1:0] IDLE_CLK    = '0,
  parameter int                CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    ch_enable,
  input  logic                 cfg_wr,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  output logic [NUM_CH-1:0]    cfg_pending,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick_out
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
    logic [DIV_WIDTH-1:0] r;
    if (d < DIV_WIDTH'(2)) begin
      r = DIV_WIDTH'(2);
    end else begin
      r = d;
    end
    return r;
  endfunction

  // ceil(d/2), one bit wider so the largest legal ratio cannot overflow
  function automatic logic [DIV_WIDTH:0] half_up(input logic [DIV_WIDTH-1:0] d);
    return ({1'b0, d} + {{DIV_WIDTH{1'b0}}, 1'b1}) >> 1;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t            state_r, state_s;
    logic [DIV_WIDTH-1:0] cnt_r, cnt_s;
    logic [DIV_WIDTH-1:0] div_act_r, div_act_s;
    logic [DIV_WIDTH-1:0] div_sh_r, div_sh_s;
    logic [DIV_WIDTH-1:0] div_eff_s, cnt_inc_s;
    logic                 pend_r, pend_s;
    logic                 clk_r, clk_s;
    logic                 tick_r, tick_s;
    logic                 wr_hit_s, boundary_s;

    // Out-of-range cfg_ch never matches any channel index, so such writes are dropped.
    assign wr_hit_s   = cfg_wr && (cfg_ch == CH_W'(i));
    assign cnt_inc_s  = cnt_r + DIV_WIDTH'(1);
    assign boundary_s = (cnt_inc_s == div_act_r);

    // Next-state and next-output logic for one channel.
    always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      div_act_s = div_act_r;
      div_sh_s  = div_sh_r;
      div_eff_s = div_act_r;
      pend_s    = pend_r;
      clk_s     = IDLE_CLK[i];
      tick_s    = 1'b0;
      case (state_r)
        IDLE: begin
          cnt_s = '0;
          if (wr_hit_s) begin
            div_sh_s  = clamp_div(cfg_div);
            div_act_s = clamp_div(cfg_div);
            pend_s    = 1'b0;
          end else if (pend_r && ch_enable[i]) begin
            div_act_s = div_sh_r;
            pend_s    = 1'b0;
          end else begin
            div_act_s = div_act_r;
          end
          if (ch_enable[i]) begin
            state_s = RUN;
            pend_s  = 1'b0;
            clk_s   = ~IDLE_CLK[i];
            tick_s  = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (!ch_enable[i]) begin
            state_s = IDLE;
            cnt_s   = '0;
          end else begin
            if (boundary_s) begin
              cnt_s = '0;
              if (pend_r) begin
                div_eff_s = div_sh_r;
                div_act_s = div_sh_r;
                pend_s    = 1'b0;
              end else begin
                div_eff_s = div_act_r;
              end
            end else begin
              cnt_s = cnt_inc_s;
            end
            clk_s  = ({1'b0, cnt_s} < half_up(div_eff_s)) ? ~IDLE_CLK[i] : IDLE_CLK[i];
            tick_s = (cnt_s == '0);
          end
          // A write landing on a boundary edge overrides the clear above and waits one more period.
          if (wr_hit_s) begin
            div_sh_s = clamp_div(cfg_div);
            pend_s   = 1'b1;
          end else begin
            div_sh_s = div_sh_r;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk_in) begin
      if (rst) begin
        state_r   <= IDLE;
        cnt_r     <= '0;
        div_act_r <= DIV_RST;
        div_sh_r  <= DIV_RST;
        pend_r    <= 1'b0;
        clk_r     <= IDLE_CLK[i];
        tick_r    <= 1'b0;
      end else begin
        state_r   <= state_s;
        cnt_r     <= cnt_s;
        div_act_r <= div_act_s;
        div_sh_r  <= div_sh_s;
        pend_r    <= pend_s;
        clk_r     <= clk_s;
        tick_r    <= tick_s;
      end
    end

    assign cfg_pending[i] = pend_r;
    assign clk_out[i]     = clk_r;
    assign tick_out[i]    = tick_r;
  end

endmodule

// File: tb/tb_prescaler_multi_channel.sv
// Directed table-driven bench for prescaler_multi_channel: 3 channels, DEFAULT_DIV=4,
// channel 2 idles high. Each table row is one clock edge with its expected outputs.
module tb_prescaler_multi_channel;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [2:0] ch_enable;
  logic       cfg_wr;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [2:0] cfg_pending;
  logic [2:0] clk_out;
  logic [2:0] tick_out;

  always #5 clk_in = ~clk_in;

  prescaler_multi_channel #(
    .NUM_CH     (3),
    .DIV_WIDTH  (8),
    .DEFAULT_DIV(4),
    .IDLE_CLK   (3'b100),
    .CH_W       (2)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .ch_enable  (ch_enable),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_pending(cfg_pending),
    .clk_out    (clk_out),
    .tick_out   (tick_out)
  );

  typedef struct {
    logic [2:0] en;
    logic       wr;
    logic [1:0] ch;
    logic [7:0] div;
    logic [2:0] exp_clk;
    logic [2:0] exp_tick;
    logic [2:0] exp_pend;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void a(input logic [2:0] en, input logic wr, input logic [1:0] ch,
                            input logic [7:0] div, input logic [2:0] c, input logic [2:0] t,
                            input logic [2:0] p);
    vec_t v;
    v.en = en; v.wr = wr; v.ch = ch; v.div = div;
    v.exp_clk = c; v.exp_tick = t; v.exp_pend = p;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [2:0] got,
                       input logic [2:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b want %b", name, idx, got, want);
    end
  endtask

  task automatic check_all(input string name, input int idx, input logic [2:0] c,
                           input logic [2:0] t, input logic [2:0] p);
    check({name, ".clk_out"}, idx, clk_out, c);
    check({name, ".tick_out"}, idx, tick_out, t);
    check({name, ".cfg_pending"}, idx, cfg_pending, p);
  endtask

  // Drive inputs, take one rising edge, then settle before sampling.
  task automatic step(input logic r, input logic [2:0] en, input logic wr,
                      input logic [1:0] ch, input logic [7:0] div);
    rst = r; ch_enable = en; cfg_wr = wr; cfg_ch = ch; cfg_div = div;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [4:0] post_clk;
    logic [4:0] post_tick;

    // T1: ch0 at default div 4
    a(3'b001,0,0,0, 3'b101,3'b001,3'b000); a(3'b001,0,0,0, 3'b101,3'b000,3'b000);
    a(3'b001,0,0,0, 3'b100,3'b000,3'b000); a(3'b001,0,0,0, 3'b100,3'b000,3'b000);
    a(3'b001,0,0,0, 3'b101,3'b001,3'b000); a(3'b001,0,0,0, 3'b101,3'b000,3'b000);
    a(3'b001,0,0,0, 3'b100,3'b000,3'b000); a(3'b001,0,0,0, 3'b100,3'b000,3'b000);
    a(3'b001,0,0,0, 3'b101,3'b001,3'b000); a(3'b001,0,0,0, 3'b101,3'b000,3'b000);
    // T3: write 6 while cnt=1, current period stays 4
    a(3'b001,1,0,6, 3'b100,3'b000,3'b001); a(3'b001,0,0,0, 3'b100,3'b000,3'b001);
    a(3'b001,0,0,0, 3'b101,3'b001,3'b000); a(3'b001,0,0,0, 3'b101,3'b000,3'b000);
    a(3'b001,0,0,0, 3'b101,3'b000,3'b000); a(3'b001,0,0,0, 3'b100,3'b000,3'b000);
    a(3'b001,0,0,0, 3'b100,3'b000,3'b000); a(3'b001,0,0,0, 3'b100,3'b000,3'b000);
    a(3'b001,0,0,0, 3'b101,3'b001,3'b000);
    // T2: ch1 written to 5 while idle, then enabled
    a(3'b000,1,1,5, 3'b100,3'b000,3'b000); a(3'b010,0,0,0, 3'b110,3'b010,3'b000);
    a(3'b010,0,0,0, 3'b110,3'b000,3'b000); a(3'b010,0,0,0, 3'b110,3'b000,3'b000);
    a(3'b010,0,0,0, 3'b100,3'b000,3'b000); a(3'b010,0,0,0, 3'b100,3'b000,3'b000);
    a(3'b010,0,0,0, 3'b110,3'b010,3'b000); a(3'b010,0,0,0, 3'b110,3'b000,3'b000);
    // T4: 7 then 9 before the boundary, last wins
    a(3'b010,1,1,7, 3'b110,3'b000,3'b010); a(3'b010,1,1,9, 3'b100,3'b000,3'b010);
    a(3'b010,0,0,0, 3'b100,3'b000,3'b010); a(3'b010,0,0,0, 3'b110,3'b010,3'b000);
    a(3'b010,0,0,0, 3'b110,3'b000,3'b000); a(3'b010,0,0,0, 3'b110,3'b000,3'b000);
    a(3'b010,1,3,2, 3'b110,3'b000,3'b000); a(3'b010,0,0,0, 3'b110,3'b000,3'b000);
    a(3'b010,0,0,0, 3'b100,3'b000,3'b000); a(3'b010,0,0,0, 3'b100,3'b000,3'b000);
    a(3'b010,0,0,0, 3'b100,3'b000,3'b000); a(3'b010,0,0,0, 3'b100,3'b000,3'b000);
    // write of 3 on the boundary edge: period of 9 repeats first
    a(3'b010,1,1,3, 3'b110,3'b010,3'b010); a(3'b010,0,0,0, 3'b110,3'b000,3'b010);
    a(3'b010,0,0,0, 3'b110,3'b000,3'b010); a(3'b010,0,0,0, 3'b110,3'b000,3'b010);
    a(3'b010,0,0,0, 3'b110,3'b000,3'b010); a(3'b010,0,0,0, 3'b100,3'b000,3'b010);
    a(3'b010,0,0,0, 3'b100,3'b000,3'b010); a(3'b010,0,0,0, 3'b100,3'b000,3'b010);
    a(3'b010,0,0,0, 3'b100,3'b000,3'b010); a(3'b010,0,0,0, 3'b110,3'b010,3'b000);
    a(3'b010,0,0,0, 3'b110,3'b000,3'b000); a(3'b010,0,0,0, 3'b100,3'b000,3'b000);
    a(3'b010,0,0,0, 3'b110,3'b010,3'b000);
    // T5: ch2 (idles high) with div 0, then div 1 while running
    a(3'b000,1,2,0, 3'b100,3'b000,3'b000); a(3'b100,0,0,0, 3'b000,3'b100,3'b000);
    a(3'b100,0,0,0, 3'b100,3'b000,3'b000); a(3'b100,0,0,0, 3'b000,3'b100,3'b000);
    a(3'b100,0,0,0, 3'b100,3'b000,3'b000); a(3'b100,1,2,1, 3'b000,3'b100,3'b100);
    a(3'b100,0,0,0, 3'b100,3'b000,3'b100); a(3'b100,0,0,0, 3'b000,3'b100,3'b000);
    a(3'b100,0,0,0, 3'b100,3'b000,3'b000);
    // T6: ch0 (div 6) dropped mid-period, then re-enabled
    a(3'b001,0,0,0, 3'b101,3'b001,3'b000); a(3'b001,0,0,0, 3'b101,3'b000,3'b000);
    a(3'b000,0,0,0, 3'b100,3'b000,3'b000); a(3'b001,0,0,0, 3'b101,3'b001,3'b000);
    a(3'b001,0,0,0, 3'b101,3'b000,3'b000); a(3'b001,0,0,0, 3'b101,3'b000,3'b000);
    a(3'b001,0,0,0, 3'b100,3'b000,3'b000);

    step(1'b1, 3'b000, 1'b0, 2'd0, 8'd0);
    step(1'b1, 3'b000, 1'b0, 2'd0, 8'd0);
    check_all("reset", 0, 3'b100, 3'b000, 3'b000);

    foreach (vecs[k]) begin
      step(1'b0, vecs[k].en, vecs[k].wr, vecs[k].ch, vecs[k].div);
      check_all("vec", k, vecs[k].exp_clk, vecs[k].exp_tick, vecs[k].exp_pend);
    end

    // Reset mid-period with a pending write must restore the default ratio of 4.
    step(1'b0, 3'b001, 1'b1, 2'd0, 8'd8);
    check_all("pre_rst", 0, 3'b100, 3'b000, 3'b001);
    step(1'b1, 3'b001, 1'b0, 2'd0, 8'd0);
    check_all("rst_mid", 0, 3'b100, 3'b000, 3'b000);
    post_clk  = 5'b10011;
    post_tick = 5'b10001;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 3'b001, 1'b0, 2'd0, 8'd0);
      check_all("post_rst", k, {2'b10, post_clk[k]}, {2'b00, post_tick[k]}, 3'b000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
